mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of alu_stage. Consumes the ALU result and the operand/control fields carried in the ID/EX bundle.
- Performs RISC-V loads and stores against the data RAM through a req/ack handshake.
- Produces the registered register-file write (address/data/enable) that replaces the current direct ALU-to-regfile path.
- Stalls upstream while a RAM transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width
- REG_ADDR_W, 5, register address width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  ALU result and control valid this cycle
- ex_ready  out  1  stage can accept an op this cycle
- alu_result  in  XLEN  ALU result; effective address for mem ops
- store_data  in  XLEN  rs2 value for stores
- funct3  in  3  access size/sign (RV32I encoding)
- mem_rd  in  1  op is a load
- mem_wr  in  1  op is a store (mem_rd and mem_wr never both 1)
- reg_wr_en_in  in  1  op writes rd
- reg_wr_addr_in  in  REG_ADDR_W  rd
- ram_req  out  1  data RAM request
- ram_we  out  1  1 = write
- ram_addr  out  XLEN  word-aligned address (low 2 bits zero)
- ram_wdata  out  XLEN  lane-replicated store data
- ram_be  out  4  byte enables
- ram_ack  in  1  RAM completes request this cycle; ram_rdata valid on the same cycle for reads
- ram_rdata  in  XLEN  read data
- wb_en  out  1  register-file write enable (1-cycle pulse)
- wb_addr  out  REG_ADDR_W  register-file write address
- wb_data  out  XLEN  register-file write data
- misalign_err  out  1  1-cycle pulse: misaligned or illegal funct3 mem op

Behaviour:
- Reset values: all outputs 0 except ex_ready = 1. FSM goes to IDLE.
- FSM states:
  - IDLE: ex_ready = 1.
  - MEM_WAIT: ex_ready = 0.
- Accept: an op is accepted when ex_valid && ex_ready. All inputs are latched at accept.
- Non-mem op accepted in IDLE:
  - Next cycle: wb_en = reg_wr_en_in && (rd != 0), wb_addr = rd, wb_data = alu_result.
  - Latency 1. Throughput 1 per cycle.
- Mem op accepted in IDLE, legal and aligned:
  - Next state is MEM_WAIT.
  - In MEM_WAIT, ram_req = 1. ram_we/addr/wdata/be stay stable until the cycle ram_ack = 1.
  - On the ack cycle: state returns to IDLE. For a load, the extended data is registered, so wb appears the cycle after ack. For a store, wb_en = 0.
  - ram_req drops the cycle after ack.
  - Minimum load latency is 3 cycles (accept, req+ack, wb). Back-to-back mem ops leave one IDLE cycle between requests.
- Alignment:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - A violation, or funct3 in {011, 110, 111}, or a store with funct3 in {100, 101}, causes: misalign_err pulses for 1 cycle; no RAM request; no wb; state stays IDLE.
- Store lanes:
  - SB: wdata = {4{b}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, be = 0011 << addr[1:0].
  - SW: be = 1111.
- Load extract:
  - Select the byte/half by addr[1:0].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes through.
  - ram_be on loads = same mask as stores (informational).
- ram_ack outside MEM_WAIT is ignored.
- reset mid-transaction (MEM_WAIT): the next cycle is IDLE with ram_req = 0 and no wb for the aborted op. A late ram_ack is ignored.
- wb_en never asserts for rd = 0.

Decomposition:
- Shared package mem_stage_pkg holds:
  - funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101
  - FSM enum {IDLE, MEM_WAIT}
  - a typedef for the latched op struct
- One sub-module, load_data_aligner: combinational extract + sign/zero extend from rdata, addr[1:0] and funct3.
- Store lane/be generation stays inline.

Test Plan:
- ALU op alu_result = 0x0000_1234, rd = 5, wr_en = 1 -> next cycle wb_en = 1, wb_addr = 5, wb_data = 0x0000_1234. Same op with rd = 0 -> wb_en = 0.
- LB addr = 0x103, ram_rdata = 0x80FF_1122, ack after 2 wait cycles -> ram_addr = 0x100, ex_ready = 0 during MEM_WAIT, wb_data = 0xFFFF_FF80. LBU same -> 0x0000_0080.
- SH addr = 0x202, store_data = 0xDEAD_BEEF -> ram_we = 1, ram_addr = 0x200, ram_be = 1100, ram_wdata = 0xBEEF_BEEF, no wb.
- LW addr = 0x301 -> misalign_err pulses once, ram_req never asserts, wb_en = 0, ex_ready stays 1.
- LW issued, reset = 1 in second MEM_WAIT cycle, ram_ack = 1 one cycle later -> ram_req = 0 after reset, no wb, ex_ready = 1.
- Alternating ALU/SW/LHU stream with ack held high -> each op completes in order, no lost or duplicated wb pulses, LHU of 0xFFFF at addr 0x2 -> 0x0000_FFFF.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access pipeline stage.
//   - RV32I load/store funct3 encodings
//   - FSM state enum
//   - latched-op struct carried from accept to writeback
//   - helpers for access legality and byte-lane masks
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes of the data RAM word.
  localparam int NUM_LANES = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Fields the load path still needs once the op has left the ID/EX bundle.
  typedef struct packed {
    logic       is_load;
    logic       wr_en;
    logic [2:0] funct3;
    logic [1:0] offset;
  } mem_op_t;

  // Legal funct3 for the direction, and natural alignment for the size.
  // Unsigned store encodings (100/101) and 011/110/111 are illegal.
  function automatic logic mem_op_legal(input logic [2:0] f3,
                                        input logic [1:0] off,
                                        input logic       is_store);
    case (f3)
      F3_B:    return 1'b1;
      F3_BU:   return !is_store;
      F3_H:    return !off[0];
      F3_HU:   return !is_store && !off[0];
      F3_W:    return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte-enable mask: size from funct3[1:0], shifted to the addressed lane.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] f3,
                                                     input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// load_data_aligner: combinational load-data extraction.
// Picks the addressed byte/halfword out of the RAM word and sign- or
// zero-extends it according to funct3. Word loads pass through.
//   rdata  : raw RAM read word
//   offset : addr[1:0] of the load
//   funct3 : RV32I load encoding
//   data   : extended value for the register file
module load_data_aligner
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  // Move the addressed lane down to bit 0.
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      F3_H:    data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline stage after the ALU. Non-memory ops are
// forwarded to a registered register-file write one cycle after accept.
// Loads/stores run a req/ack transaction against the data RAM and hold off
// upstream (ex_ready = 0) until the RAM acknowledges.
// Ports:
//   clk, reset           pipeline clock, synchronous active-high reset
//   ex_valid / ex_ready  op handshake from the ALU stage
//   alu_result           result or effective address
//   store_data, funct3   store value and access size/sign
//   mem_rd, mem_wr       load / store op
//   reg_wr_en_in/addr_in destination register write request
//   ram_*                data RAM request (word address, lane data, byte enables)
//   ram_ack, ram_rdata   RAM completion and read data (same cycle)
//   wb_en/addr/data      registered register-file write
//   misalign_err         pulse for a misaligned or illegal memory op
// The data lanes assume XLEN = 32 (four byte lanes).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       store_data,
  input  logic [2:0]            funct3,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic                  reg_wr_en_in,
  input  logic [REG_ADDR_W-1:0] reg_wr_addr_in,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [XLEN-1:0]       ram_addr,
  output logic [XLEN-1:0]       ram_wdata,
  output logic [3:0]            ram_be,
  input  logic                  ram_ack,
  input  logic [XLEN-1:0]       ram_rdata,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic                  misalign_err
);

  state_e                      state;
  mem_op_t                     op;
  logic [REG_ADDR_W-1:0]       op_rd;

  logic                        accept;
  logic                        is_mem;
  logic                        op_legal;
  logic [NUM_LANES-1:0]        be_nxt;
  logic [NUM_LANES-1:0][7:0]   wlane;
  logic [XLEN-1:0]             ld_data;

  assign accept   = ex_valid && ex_ready;
  assign is_mem   = mem_rd || mem_wr;
  assign op_legal = mem_op_legal(funct3, alu_result[1:0], mem_wr);
  assign be_nxt   = lane_mask(funct3, alu_result[1:0]);

  // Replicate the store value across lanes so the RAM only needs byte
  // enables: bytes go to every lane, halves to every lane pair.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wlane[i] = (funct3[1:0] == 2'b00) ? store_data[7:0]
                    : (funct3[1:0] == 2'b01) ? store_data[8*(i%2) +: 8]
                    :                          store_data[8*i +: 8];
  end

  // Extraction works off the latched offset/funct3 since the ID/EX
  // fields have moved on by the time the RAM answers.
  load_data_aligner #(.XLEN(XLEN)) u_align (
    .rdata  (ram_rdata),
    .offset (op.offset),
    .funct3 (op.funct3),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ex_ready     <= 1'b1;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_be       <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      op           <= '0;
      op_rd        <= '0;
    end else begin
      // Writeback and error are single-cycle pulses.
      wb_en        <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_en   <= reg_wr_en_in && (reg_wr_addr_in != '0);
              wb_addr <= reg_wr_addr_in;
              wb_data <= alu_result;
            end else if (!op_legal) begin
              // Dropped: no RAM traffic, no writeback, stay ready.
              misalign_err <= 1'b1;
            end else begin
              state     <= MEM_WAIT;
              ex_ready  <= 1'b0;
              ram_req   <= 1'b1;
              ram_we    <= mem_wr;
              ram_addr  <= {alu_result[XLEN-1:2], 2'b00};
              ram_wdata <= wlane;
              ram_be    <= be_nxt;
              op        <= '{is_load: mem_rd,
                              wr_en:   reg_wr_en_in,
                              funct3:  funct3,
                              offset:  alu_result[1:0]};
              op_rd     <= reg_wr_addr_in;
            end
          end
        end
        MEM_WAIT: begin
          // Request fields are held untouched until the ack cycle.
          if (ram_ack) begin
            state    <= IDLE;
            ex_ready <= 1'b1;
            ram_req  <= 1'b0;
            ram_we   <= 1'b0;
            if (op.is_load) begin
              wb_en   <= op.wr_en && (op_rd != '0);
              wb_addr <= op_rd;
              wb_data <= ld_data;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ex_ready <= 1'b1;
          ram_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_wr_en_in;
  logic [4:0]  reg_wr_addr_in;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign_err;

  mem_access_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .store_data(store_data), .funct3(funct3),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr_en_in(reg_wr_en_in),
    .reg_wr_addr_in(reg_wr_addr_in), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment RAM (word array) and reference memory (plain bytes).
  logic [31:0] ram [0:255];
  logic [7:0]  ref_mem [0:1023];

  task automatic poke(input int a, input logic [31:0] w);
    ram[a >> 2] = w;
    for (int k = 0; k < 4; k++) ref_mem[(a & ~3) + k] = w[8*k +: 8];
  endtask

  // RAM responder: acks after ack_delay extra request cycles, records what
  // was acked and whether request fields moved while waiting.
  int          ack_delay = 0;
  bit          force_ack = 1'b0;
  int          wait_cnt  = 0;
  bit          prev_req  = 1'b0;
  int          hold_viol = 0;
  logic [31:0] s_addr, s_wdata, ack_addr, ack_wdata;
  logic [3:0]  s_be, ack_be;
  logic        s_we;

  initial begin
    ram_ack   = 1'b0;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      ram_ack   = 1'b0;
      ram_rdata = $urandom;
      if (ram_req === 1'b1) begin
        if (prev_req) begin
          if (ram_addr !== s_addr || ram_we !== s_we || ram_be !== s_be || ram_wdata !== s_wdata)
            hold_viol++;
        end else begin
          s_addr = ram_addr; s_we = ram_we; s_be = ram_be; s_wdata = ram_wdata;
        end
        if (wait_cnt >= ack_delay) begin
          ram_ack   = 1'b1;
          wait_cnt  = 0;
          ack_addr  = ram_addr;
          ack_be    = ram_be;
          ack_wdata = ram_wdata;
          if (ram_we !== 1'b1) ram_rdata = ram[ram_addr[9:2]];
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      prev_req = (ram_req === 1'b1);
      if (force_ack) ram_ack = 1'b1;
    end
  end

  // Writeback pulse monitor.
  int wb_seen = 0;
  int wb_zero = 0;
  int exp_wb  = 0;
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      wb_seen++;
      if (wb_addr == 5'd0) wb_zero++;
    end
  end

  // One op through the stage, checked against the byte-memory model.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input bit wr, input logic [4:0] rd, input int dly,
                       output logic [31:0] wbv);
    int          size;
    int          req_cycles;
    bit          legal;
    bit          exp_en;
    int          mask;
    logic [31:0] v;
    logic [31:0] rep;
    ack_delay = dly;
    chk("issue_ready", ex_ready, 1);
    ex_valid = 1'b1; alu_result = a; store_data = sd; funct3 = f3;
    mem_rd = ld; mem_wr = st; reg_wr_en_in = wr; reg_wr_addr_in = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    exp_en = wr && (rd != 5'd0);
    if (!(ld || st)) begin
      chk("alu_wb_en", wb_en, exp_en);
      if (exp_en) begin
        exp_wb++;
        chk("alu_wb_addr", wb_addr, rd);
        chk("alu_wb_data", wb_data, a);
      end
      chk("alu_no_req", ram_req, 0);
    end else begin
      case (f3)
        F3_B, F3_BU: size = 1;
        F3_H, F3_HU: size = 2;
        F3_W:        size = 4;
        default:     size = 0;
      endcase
      legal = (size != 0) && !(st && (f3 == F3_BU || f3 == F3_HU)) && (a % size == 0);
      if (!legal) begin
        chk("bad_err", misalign_err, 1);
        chk("bad_req", ram_req, 0);
        chk("bad_wb", wb_en, 0);
        chk("bad_ready", ex_ready, 1);
        @(posedge clk); #1;
        chk("bad_err_pulse", misalign_err, 0);
        chk("bad_req2", ram_req, 0);
      end else begin
        mask = ((1 << size) - 1) << (a & 3);
        chk("req", ram_req, 1);
        chk("we", ram_we, st);
        chk("addr", ram_addr, a & ~32'd3);
        chk("be", ram_be, mask & 15);
        if (st) begin
          rep = (size == 1) ? sd[7:0] * 32'h0101_0101 :
                (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
          chk("wdata", ram_wdata, rep);
        end
        req_cycles = 0;
        while (ram_req === 1'b1 && req_cycles < 64) begin
          chk("wait_ready", ex_ready, 0);
          req_cycles++;
          @(posedge clk); #1;
        end
        chk("req_cycles", req_cycles, dly + 1);
        chk("done_ready", ex_ready, 1);
        chk("no_err", misalign_err, 0);
        if (ld) begin
          v = '0;
          for (int k = 0; k < size; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
          if (f3 == F3_B && v[7])  v = v | 32'hFFFF_FF00;
          if (f3 == F3_H && v[15]) v = v | 32'hFFFF_0000;
          chk("ld_wb_en", wb_en, exp_en);
          if (exp_en) begin
            exp_wb++;
            chk("ld_wb_addr", wb_addr, rd);
            chk("ld_wb_data", wb_data, v);
          end
        end else begin
          chk("st_no_wb", wb_en, 0);
          for (int k = 0; k < size; k++) ref_mem[a + k] = 8'(sd >> (8 * k));
          for (int i = 0; i < 4; i++)
            if (ack_be[i]) ram[ack_addr[9:2]][8*i +: 8] = ack_wdata[8*i +: 8];
        end
      end
    end
    wbv = wb_data;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;
    reset = 1'b1; ex_valid = 1'b0; alu_result = '0; store_data = '0;
    funct3 = '0; mem_rd = 1'b0; mem_wr = 1'b0; reg_wr_en_in = 1'b0;
    reg_wr_addr_in = '0;
    for (int i = 0; i < 256; i++) poke(i * 4, $urandom);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", ram_req, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_be", ram_be, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", misalign_err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ALU writeback, then the same op to x0.
    do_op(0, 0, F3_W, 32'h0000_1234, 0, 1, 5'd5, 0, v);
    chk("alu_rd5_data", v, 32'h0000_1234);
    do_op(0, 0, F3_W, 32'h0000_1234, 0, 1, 5'd0, 0, v);

    // Byte loads from 0x103 with two wait cycles.
    poke(32'h100, 32'h80FF_1122);
    do_op(1, 0, F3_B, 32'h103, 0, 1, 5'd7, 2, v);
    chk("lb_0x103", v, 32'hFFFF_FF80);
    do_op(1, 0, F3_BU, 32'h103, 0, 1, 5'd8, 2, v);
    chk("lbu_0x103", v, 32'h0000_0080);

    // Upper-half store, then misaligned word load.
    do_op(0, 1, F3_H, 32'h202, 32'hDEAD_BEEF, 0, 5'd0, 1, v);
    do_op(1, 0, F3_W, 32'h301, 0, 1, 5'd9, 0, v);

    // Reset in the second MEM_WAIT cycle, late ack afterwards.
    ack_delay = 100;
    chk("rt_ready", ex_ready, 1);
    ex_valid = 1'b1; mem_rd = 1'b1; funct3 = F3_W; alu_result = 32'h40;
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd3;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_rd = 1'b0;
    chk("rt_req1", ram_req, 1);
    @(posedge clk); #1;
    chk("rt_req2", ram_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; force_ack = 1'b1;
    chk("rt_req_off", ram_req, 0);
    chk("rt_ready_back", ex_ready, 1);
    chk("rt_no_wb", wb_en, 0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    chk("rt_late_ack_req", ram_req, 0);
    chk("rt_late_ack_wb", wb_en, 0);
    chk("rt_late_ack_ready", ex_ready, 1);

    // ALU / SW / LHU stream with immediate acks.
    for (int r = 0; r < 3; r++) begin
      do_op(0, 0, F3_W, $urandom, 0, 1, 5'(r + 10), 0, v);
      do_op(0, 1, F3_W, 32'h0, {16'hFFFF, 16'($urandom)}, 0, 5'd0, 0, v);
      do_op(1, 0, F3_HU, 32'h2, 0, 1, 5'(r + 20), 0, v);
      chk("lhu_0x2", v, 32'h0000_FFFF);
    end

    // Random mix.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      f3 = 3'($urandom);
      a = $urandom_range(0, 1023);
      case ($urandom_range(0, 2))
        1: a = a & ~32'd1;
        2: a = a & ~32'd3;
        default: ;
      endcase
      if (kind == 0)
        do_op(0, 0, f3, $urandom, $urandom, ($urandom % 4) != 0, 5'($urandom), 0, v);
      else
        do_op(kind == 1, kind == 2, f3, a, $urandom, ($urandom % 4) != 0,
              5'($urandom), $urandom_range(0, 3), v);
    end

    @(posedge clk); #1;
    chk("wb_pulse_count", wb_seen, exp_wb);
    chk("wb_to_x0", wb_zero, 0);
    chk("req_fields_held", hold_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
